// File: rtl/maxpool2x2_line.sv
// maxpool2x2_line: streaming 2x2 stride-2 signed max-pool over a raster pixel stream.
// Ports:
//   clk, resetn     - clock, async active-low reset
//   clear           - synchronous frame resync (wins over in_valid)
//   in_valid, x     - input pixel beat (signed WIDTH)
//   out_valid, out  - pooled pixel, one-cycle pulse per 2x2 window
//   out_last        - marks the final pooled pixel of a frame
module maxpool2x2_line #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IMG_W = 32,
  parameter int unsigned IMG_H = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] x,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out,
  output logic                    out_last
);

  localparam int unsigned HALF_W = IMG_W / 2;
  localparam int unsigned CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned IW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  function automatic logic signed [WIDTH-1:0] smax(input logic signed [WIDTH-1:0] a,
                                                   input logic signed [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic signed [WIDTH-1:0] hold_q, hold_d;
  logic signed [WIDTH-1:0] out_q, out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic signed [WIDTH-1:0] lbuf_q [HALF_W];

  logic                    lbuf_we;
  logic [IW-1:0]           lbuf_idx;
  logic signed [WIDTH-1:0] pair_max;
  logic signed [WIDTH-1:0] lbuf_rd;
  logic                    col_last, row_last;

  // Window datapath: the even row leaves its pair maximum in lbuf, the odd row closes the window.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    lbuf_we     = 1'b0;
    lbuf_idx    = IW'(col_q >> 1);
    pair_max    = smax(hold_q, x);
    lbuf_rd     = lbuf_q[lbuf_idx];
    col_last    = (col_q == CW'(IMG_W - 1));
    row_last    = (row_q == RW'(IMG_H - 1));

    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (in_valid) begin
      if (!col_q[0]) begin
        hold_d = x;
      end else if (!row_q[0]) begin
        lbuf_we = 1'b1;
      end else begin
        out_d       = smax(lbuf_rd, pair_max);
        out_valid_d = 1'b1;
        out_last_d  = row_last && col_last;
      end

      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Counters, hold register and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Line buffer of even-row pair maxima; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (lbuf_we) begin
      lbuf_q[lbuf_idx] <= pair_max;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool2x2_line.sv
// tb_maxpool2x2_line: scoreboard bench for maxpool2x2_line on a 4x4 frame.
module tb_maxpool2x2_line;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned IMG_W = 4;
  localparam int unsigned IMG_H = 4;
  localparam int unsigned NPIX  = IMG_W * IMG_H;

  typedef struct packed {
    logic signed [WIDTH-1:0] data;
    logic                    last;
    logic [31:0]             cyc;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    resetn;
  logic                    clear;
  logic                    in_valid;
  logic signed [WIDTH-1:0] x;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out;
  logic                    out_last;

  exp_t                    sb[$];
  int unsigned             cyc = 0;
  int                      n_chk = 0;
  int                      n_pass = 0;
  logic signed [WIDTH-1:0] px [NPIX];
  logic signed [WIDTH-1:0] exp_v [4];
  int                      ramp_exp [4] = '{5, 7, 13, 15};

  maxpool2x2_line #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (clear),
    .in_valid (in_valid),
    .x        (x),
    .out_valid(out_valid),
    .out      (out),
    .out_last (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard, including its cycle.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_out: got out=%0d last=%0b at cycle %0d, expected no pulse",
                   out, out_last, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          n_chk++;
          if (out === e.data && out_last === e.last && cyc == e.cyc) n_pass++;
          else $display("FAIL pooled_out: got out=%0d last=%0b cyc=%0d expected out=%0d last=%0b cyc=%0d",
                        out, out_last, cyc, e.data, e.last, e.cyc);
        end
      end else if (out_last) begin
        n_chk++;
        $display("FAIL stray_last: got out_last=1 with out_valid=0, expected 0");
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      clear    = 1'b0;
    end
  endtask

  task automatic beat(input logic signed [WIDTH-1:0] v);
    @(negedge clk);
    in_valid = 1'b1;
    clear    = 1'b0;
    x        = v;
  endtask

  task automatic set_ramp(input int base);
    for (int i = 0; i < int'(NPIX); i++) px[i] = WIDTH'(base + i);
    for (int j = 0; j < 4; j++) exp_v[j] = WIDTH'(base + ramp_exp[j]);
  endtask

  // Feed the first n pixels of px; odd-row/odd-col beats queue the matching expected window.
  task automatic run_pixels(input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      int r;
      int c;
      r = i / int'(IMG_W);
      c = i % int'(IMG_W);
      if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
      beat(px[i]);
      if ((r % 2 == 1) && (c % 2 == 1))
        sb.push_back('{data: exp_v[(r / 2) * 2 + c / 2], last: (i == int'(NPIX) - 1),
                       cyc: cyc + 1});
    end
  endtask

  initial begin
    resetn   = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    x        = '0;
    repeat (3) @(negedge clk);
    check("reset_out", 32'(out), 32'(0));
    check("reset_valid", 32'(out_valid), 32'(0));
    check("reset_last", 32'(out_last), 32'(0));
    resetn = 1'b1;
    idle(2);

    // Basic ramp frame
    set_ramp(0);
    run_pixels(NPIX, 0);
    idle(3);

    // Signed, tie and most-negative windows
    px = '{-16'sd3, -16'sd128, 16'sd200, 16'sd50,
           -16'sd1, -16'sd1, 16'sd7, 16'sd300,
           -16'sd32768, -16'sd32768, 16'sd5, -16'sd5,
           -16'sd32768, -16'sd32768, -16'sd10, -16'sd20};
    exp_v = '{-16'sd1, 16'sd300, -16'sd32768, 16'sd5};
    run_pixels(NPIX, 0);
    idle(3);

    // Gapped input
    set_ramp(0);
    run_pixels(NPIX, 5);
    idle(3);

    // Back-to-back frames
    set_ramp(0);
    run_pixels(NPIX, 0);
    set_ramp(100);
    run_pixels(NPIX, 0);
    idle(3);

    // Mid-frame async reset right as a pooled pulse is visible
    set_ramp(0);
    run_pixels(5, 0);
    beat(px[5]);
    @(posedge clk);
    #2;
    check("pre_reset_valid", 32'(out_valid), 32'(1));
    check("pre_reset_out", 32'(out), 32'(5));
    resetn = 1'b0;
    #1;
    check("midreset_valid", 32'(out_valid), 32'(0));
    check("midreset_out", 32'(out), 32'(0));
    @(negedge clk);
    in_valid = 1'b0;
    resetn   = 1'b1;
    run_pixels(NPIX, 0);
    idle(3);

    // Mid-frame clear
    run_pixels(6, 0);
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    check("clear_valid", 32'(out_valid), 32'(0));
    run_pixels(NPIX, 0);
    idle(3);

    // clear with in_valid: pixel must be dropped
    run_pixels(3, 0);
    @(negedge clk);
    in_valid = 1'b1;
    x        = 16'sd999;
    clear    = 1'b1;
    idle(1);
    run_pixels(NPIX, 0);
    idle(5);

    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
